register_bank_scoreboard: RTL and testbench
===========================================

# register_bank_scoreboard

Parametrised integer register bank for the pipelined RISC-V core. It replaces the fixed two-read/one-write bank of the single-cycle datapath. It provides N combinational read ports with write-first bypass and hard-wired x0. It also keeps a per-register pending-write scoreboard, so the decode stage can stall on RAW hazards and on scoreboard saturation. The block sits between decode (issue side) and writeback (write side).

## Interface
- XLEN, 32, data width of every register
- NUM_REGS, 32, register count; register 0 is hard-wired to zero
- NUM_READ_PORTS, 2, number of independent read ports (>=1)
- MAX_INFLIGHT, 3, maximum outstanding issued-but-not-written-back writes per register
- ADDR_W, $clog2(NUM_REGS), register address width (derived, not overridden)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_READ_PORTS x ADDR_W  read addresses
- rd_data  out  NUM_READ_PORTS x XLEN  read data (combinational)
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  XLEN  writeback value
- issue_valid  in  1  decode presents an instruction
- issue_rs_used  in  NUM_READ_PORTS  mask: read port i is a true source of the issuing instruction
- issue_rd_we  in  1  issuing instruction writes issue_rd
- issue_rd  in  ADDR_W  destination of the issuing instruction
- stall  out  1  issue refused this cycle (combinational)
- flush  in  1  discard all pending-write tracking (mispredict/exception)
- sb_error  out  1  sticky: writeback arrived for a register with zero pending count

## Operation
- Storage: NUM_REGS-1 physical registers; all are zero after reset.
- Read port i:
  - rd_addr==0 -> 0.
  - Otherwise, if wr_en && wr_addr==rd_addr -> wr_data (write-first bypass).
  - Otherwise -> stored value.
- Write: on clk edge, if wr_en && wr_addr!=0, reg[wr_addr] <= wr_data. Writes to x0 are silently dropped.
- Scoreboard: counter pend[r] per register, width $clog2(MAX_INFLIGHT+1). pend[0] is held at 0.
  - wb_dec(r) = wr_en && wr_addr==r && r!=0.
  - raw_hit(i) = issue_rs_used[i] && rd_addr[i]!=0 && (pend[rd_addr[i]] - wb_dec(rd_addr[i])) != 0. A writeback this cycle that retires the last pending write resolves the hazard through bypass.
  - full_hit = issue_rd_we && issue_rd!=0 && pend[issue_rd]==MAX_INFLIGHT && !wb_dec(issue_rd).
  - stall = issue_valid && !flush && (any raw_hit(i) || full_hit).
  - accept = issue_valid && !stall && !flush.
- Counter update per register r, per edge:
  - flush -> pend[r] <= 0.
  - Otherwise pend[r] <= pend[r] + (accept && issue_rd_we && issue_rd==r && r!=0) - (wb_dec(r) && pend[r]!=0).
  - A simultaneous increment and decrement on the same register leaves the count unchanged.
- sb_error is set on an edge where wr_en && wr_addr!=0 && pend[wr_addr]==0 && !flush. It clears only on reset. The register data is still written.
- flush does not affect register contents or a concurrent writeback's data write.

## Timing
- Reads: zero latency (combinational from rd_addr, wr_*).
- Write: visible in storage the cycle after the edge; visible the same cycle via bypass.
- stall: combinational from issue_*, rd_addr, wr_*, flush and the counters. Decode holds its instruction while stall=1.
- Reset (asserted at any time, including mid-operation): all registers and pend[] = 0, sb_error = 0 immediately. stall therefore evaluates to 0 while the counters are zero.
- Deassertion of rst_n is synchronised externally; the block assumes a clean release.

## Structure
- Package register_bank_pkg holds:
  - XLEN_DEFAULT, NUM_REGS_DEFAULT, ZERO_REG constant (0).
  - reg_addr_t typedef (logic [4:0]).
  - pend_cnt_t typedef sized for the default MAX_INFLIGHT.
- Sub-module register_scoreboard holds pend[], stall, accept and sb_error logic. The top module holds storage, read muxes and bypass, and instantiates the scoreboard.

## Test plan
- Reset then read all ports at addr 5 -> 0. Write x5=0xDEADBEEF, read port 1 at addr 5 the same cycle -> 0xDEADBEEF (bypass); next cycle -> 0xDEADBEEF. Write x0=0x1234 -> read x0 = 0.
- Issue rd=x7 (accepted), next cycle issue with rs1=x7 used -> stall=1. Writeback x7 that cycle -> stall=0 and rd_data[0] = wr_data.
- Issue x9 three times with MAX_INFLIGHT=3, fourth issue to x9 -> stall=1. Same cycle writeback x9 -> stall=0 and pend[x9] stays 3.
- Pend x3=2, assert flush with issue_valid -> stall=0, issue not recorded, pend all 0. Subsequent writeback x3 -> sb_error=1 and x3 still written.
- NUM_READ_PORTS=3, XLEN=64: three distinct sources, one pending -> stall=1. Clear it via writeback -> 64-bit bypass value on the matching port only.
- Assert rst_n=0 mid-sequence with pend nonzero and sb_error=1 -> all outputs zero immediately, registers read 0 after release.

Source files
------------

// File: rtl/register_bank_pkg.sv
// Shared types and defaults for the integer register bank and its pending-write scoreboard.
package register_bank_pkg;

  localparam int XLEN_DEFAULT         = 32;
  localparam int NUM_REGS_DEFAULT     = 32;
  localparam int MAX_INFLIGHT_DEFAULT = 3;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef logic [4:0] reg_addr_t;

  function automatic int pend_width(input int max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

  typedef logic [pend_width(MAX_INFLIGHT_DEFAULT)-1:0] pend_cnt_t;

endpackage

// File: rtl/register_scoreboard.sv
// Per-register pending-write counters, RAW/saturation stall generation and the sticky
// writeback-without-pending error flag.
module register_scoreboard
  import register_bank_pkg::*;
#(
  parameter int NUM_REGS       = NUM_REGS_DEFAULT,
  parameter int NUM_READ_PORTS = 2,
  parameter int MAX_INFLIGHT   = MAX_INFLIGHT_DEFAULT,
  parameter int ADDR_W         = $clog2(NUM_REGS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_READ_PORTS-1:0][ADDR_W-1:0] rd_addr,
  input  logic                                  wr_en,
  input  logic [ADDR_W-1:0]                     wr_addr,
  input  logic                                  issue_valid,
  input  logic [NUM_READ_PORTS-1:0]             issue_rs_used,
  input  logic                                  issue_rd_we,
  input  logic [ADDR_W-1:0]                     issue_rd,
  input  logic                                  flush,
  output logic                                  stall,
  output logic                                  sb_error
);

  localparam int PEND_W = pend_width(MAX_INFLIGHT);
  localparam int SLOTS  = 1 << ADDR_W;
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_INFLIGHT);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  // Slots at or above NUM_REGS exist only so every address indexes in range; they stay zero.
  logic [PEND_W-1:0]         pend_r [SLOTS];
  logic [NUM_READ_PORTS-1:0] raw_hit_s;
  logic [SLOTS-1:0]          inc_s;
  logic [SLOTS-1:0]          dec_s;
  logic                      full_hit_s;
  logic                      stall_s;
  logic                      accept_s;
  logic                      sb_error_r;

  function automatic logic wb_hit(input logic en, input logic [ADDR_W-1:0] wa,
                                  input logic [ADDR_W-1:0] a);
    return en && (wa == a) && (a != ADDR_ZERO);
  endfunction

  // Hazard detection, issue acceptance and per-register counter deltas.
  always_comb begin
    raw_hit_s = {NUM_READ_PORTS{1'b0}};
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      // A writeback retiring the last pending write is covered by the read bypass.
      if (issue_rs_used[i] && (rd_addr[i] != ADDR_ZERO) && (pend_r[rd_addr[i]] != PEND_ZERO) &&
          !((pend_r[rd_addr[i]] == PEND_ONE) && wb_hit(wr_en, wr_addr, rd_addr[i]))) begin
        raw_hit_s[i] = 1'b1;
      end else begin
        raw_hit_s[i] = 1'b0;
      end
    end
    full_hit_s = issue_rd_we && (issue_rd != ADDR_ZERO) && (pend_r[issue_rd] == PEND_MAX) &&
                 !wb_hit(wr_en, wr_addr, issue_rd);
    stall_s    = issue_valid && !flush && ((|raw_hit_s) || full_hit_s);
    accept_s   = issue_valid && !stall_s && !flush;
    inc_s      = {SLOTS{1'b0}};
    dec_s      = {SLOTS{1'b0}};
    for (int r = 1; r < SLOTS; r++) begin
      inc_s[r] = accept_s && issue_rd_we && (issue_rd == ADDR_W'(r)) && (r < NUM_REGS);
      dec_s[r] = wb_hit(wr_en, wr_addr, ADDR_W'(r)) && (pend_r[r] != PEND_ZERO);
    end
  end

  // Pending-write counters; flush wipes all tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < SLOTS; r++) pend_r[r] <= PEND_ZERO;
    end else if (flush) begin
      for (int r = 0; r < SLOTS; r++) pend_r[r] <= PEND_ZERO;
    end else begin
      for (int r = 0; r < SLOTS; r++) begin
        if ((r == 0) || (r >= NUM_REGS)) begin
          pend_r[r] <= PEND_ZERO;
        end else begin
          case ({inc_s[r], dec_s[r]})
            2'b10:   pend_r[r] <= pend_r[r] + PEND_ONE;
            2'b01:   pend_r[r] <= pend_r[r] - PEND_ONE;
            default: pend_r[r] <= pend_r[r];
          endcase
        end
      end
    end
  end

  // Sticky flag for a writeback that had no matching issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_error_r <= 1'b0;
    end else if (wr_en && (wr_addr != ADDR_ZERO) && (pend_r[wr_addr] == PEND_ZERO) && !flush) begin
      sb_error_r <= 1'b1;
    end
  end

  assign stall    = stall_s;
  assign sb_error = sb_error_r;

endmodule

// File: rtl/register_bank_scoreboard.sv
// Multi-port integer register bank with write-first bypass, hard-wired x0 and an
// attached pending-write scoreboard for decode-stage hazard stalls.
module register_bank_scoreboard
  import register_bank_pkg::*;
#(
  parameter  int XLEN           = XLEN_DEFAULT,
  parameter  int NUM_REGS       = NUM_REGS_DEFAULT,
  parameter  int NUM_READ_PORTS = 2,
  parameter  int MAX_INFLIGHT   = MAX_INFLIGHT_DEFAULT,
  localparam int ADDR_W         = $clog2(NUM_REGS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_READ_PORTS-1:0][ADDR_W-1:0] rd_addr,
  output logic [NUM_READ_PORTS-1:0][XLEN-1:0]   rd_data,
  input  logic                                  wr_en,
  input  logic [ADDR_W-1:0]                     wr_addr,
  input  logic [XLEN-1:0]                       wr_data,
  input  logic                                  issue_valid,
  input  logic [NUM_READ_PORTS-1:0]             issue_rs_used,
  input  logic                                  issue_rd_we,
  input  logic [ADDR_W-1:0]                     issue_rd,
  output logic                                  stall,
  input  logic                                  flush,
  output logic                                  sb_error
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [XLEN-1:0]                       regs_r [1:NUM_REGS-1];
  logic [NUM_READ_PORTS-1:0][XLEN-1:0]   stored_s;
  logic [NUM_READ_PORTS-1:0][XLEN-1:0]   rd_data_s;

  // Register storage; x0 has no physical flop, so writes to it fall through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < NUM_REGS; r++) regs_r[r] <= {XLEN{1'b0}};
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (wr_en && (wr_addr == ADDR_W'(r))) regs_r[r] <= wr_data;
      end
    end
  end

  // Read muxes: x0 reads zero, a same-cycle writeback wins over storage.
  always_comb begin
    stored_s  = {NUM_READ_PORTS{{XLEN{1'b0}}}};
    rd_data_s = {NUM_READ_PORTS{{XLEN{1'b0}}}};
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        stored_s[i] = (rd_addr[i] == ADDR_W'(r)) ? regs_r[r] : stored_s[i];
      end
      if (rd_addr[i] == ADDR_ZERO) begin
        rd_data_s[i] = {XLEN{1'b0}};
      end else if (wr_en && (wr_addr == rd_addr[i])) begin
        rd_data_s[i] = wr_data;
      end else begin
        rd_data_s[i] = stored_s[i];
      end
    end
  end

  assign rd_data = rd_data_s;

  register_scoreboard #(
    .NUM_REGS       (NUM_REGS),
    .NUM_READ_PORTS (NUM_READ_PORTS),
    .MAX_INFLIGHT   (MAX_INFLIGHT),
    .ADDR_W         (ADDR_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_addr       (rd_addr),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .issue_valid   (issue_valid),
    .issue_rs_used (issue_rs_used),
    .issue_rd_we   (issue_rd_we),
    .issue_rd      (issue_rd),
    .flush         (flush),
    .stall         (stall),
    .sb_error      (sb_error)
  );

endmodule

// File: tb/tb_register_bank_scoreboard.sv
// Directed bench: stimulus queues expected outputs, a negedge monitor pops and compares them.
module tb_register_bank_scoreboard;

  logic clk;
  logic rst_n;

  // Default configuration: 2 ports, 32-bit, MAX_INFLIGHT=3
  logic [1:0][4:0]  a_rd_addr;
  logic [1:0][31:0] a_rd_data;
  logic             a_wr_en;
  logic [4:0]       a_wr_addr;
  logic [31:0]      a_wr_data;
  logic             a_issue_valid;
  logic [1:0]       a_issue_rs_used;
  logic             a_issue_rd_we;
  logic [4:0]       a_issue_rd;
  logic             a_stall;
  logic             a_flush;
  logic             a_sb_error;

  // Wide configuration: 3 ports, 64-bit
  logic [2:0][4:0]  b_rd_addr;
  logic [2:0][63:0] b_rd_data;
  logic             b_wr_en;
  logic [4:0]       b_wr_addr;
  logic [63:0]      b_wr_data;
  logic             b_issue_valid;
  logic [2:0]       b_issue_rs_used;
  logic             b_issue_rd_we;
  logic [4:0]       b_issue_rd;
  logic             b_stall;
  logic             b_flush;
  logic             b_sb_error;

  register_bank_scoreboard dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .issue_valid(a_issue_valid), .issue_rs_used(a_issue_rs_used),
    .issue_rd_we(a_issue_rd_we), .issue_rd(a_issue_rd), .stall(a_stall),
    .flush(a_flush), .sb_error(a_sb_error)
  );

  register_bank_scoreboard #(.XLEN(64), .NUM_READ_PORTS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .issue_valid(b_issue_valid), .issue_rs_used(b_issue_rs_used),
    .issue_rd_we(b_issue_rd_we), .issue_rd(b_issue_rd), .stall(b_stall),
    .flush(b_flush), .sb_error(b_sb_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expectation queues: selector, expected value, comparison name
  int          q_sel[$];
  logic [63:0] q_exp[$];
  string       q_name[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam int A_RD0 = 0, A_RD1 = 1, A_STALL = 3, A_SBERR = 4;
  localparam int B_RD0 = 5, B_RD1 = 6, B_RD2 = 7, B_STALL = 8, B_SBERR = 9;

  task automatic chk(input int sel, input logic [63:0] exp, input string name);
    q_sel.push_back(sel);
    q_exp.push_back(exp);
    q_name.push_back(name);
  endtask

  function automatic logic [63:0] act(input int sel);
    case (sel)
      A_RD0:   return {32'd0, a_rd_data[0]};
      A_RD1:   return {32'd0, a_rd_data[1]};
      A_STALL: return {63'd0, a_stall};
      A_SBERR: return {63'd0, a_sb_error};
      B_RD0:   return b_rd_data[0];
      B_RD1:   return b_rd_data[1];
      B_RD2:   return b_rd_data[2];
      B_STALL: return {63'd0, b_stall};
      B_SBERR: return {63'd0, b_sb_error};
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Monitor: compare every queued expectation against the settled outputs
  always @(negedge clk) begin
    int          sel;
    logic [63:0] e;
    logic [63:0] a;
    string       nm;
    while (q_sel.size() > 0) begin
      sel = q_sel.pop_front();
      e   = q_exp.pop_front();
      nm  = q_name.pop_front();
      a   = act(sel);
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, a, e, $time);
      end
    end
  end

  task automatic a_cyc(input logic iv, input logic [1:0] rsu, input logic [4:0] ra0,
                       input logic [4:0] ra1, input logic rdwe, input logic [4:0] rd,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic fl);
    @(posedge clk);
    #1;
    a_issue_valid = iv;  a_issue_rs_used = rsu;
    a_rd_addr[0] = ra0;  a_rd_addr[1] = ra1;
    a_issue_rd_we = rdwe; a_issue_rd = rd;
    a_wr_en = we; a_wr_addr = wa; a_wr_data = wd;
    a_flush = fl;
  endtask

  task automatic b_cyc(input logic iv, input logic [2:0] rsu, input logic [4:0] ra0,
                       input logic [4:0] ra1, input logic [4:0] ra2, input logic rdwe,
                       input logic [4:0] rd, input logic we, input logic [4:0] wa,
                       input logic [63:0] wd);
    @(posedge clk);
    #1;
    b_issue_valid = iv; b_issue_rs_used = rsu;
    b_rd_addr[0] = ra0; b_rd_addr[1] = ra1; b_rd_addr[2] = ra2;
    b_issue_rd_we = rdwe; b_issue_rd = rd;
    b_wr_en = we; b_wr_addr = wa; b_wr_data = wd;
    b_flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_rd_addr = {5'd5, 5'd5}; a_wr_en = 1'b0; a_wr_addr = 5'd0; a_wr_data = 32'd0;
    a_issue_valid = 1'b0; a_issue_rs_used = 2'b00; a_issue_rd_we = 1'b0;
    a_issue_rd = 5'd0; a_flush = 1'b0;
    b_rd_addr = {5'd0, 5'd0, 5'd0}; b_wr_en = 1'b0; b_wr_addr = 5'd0; b_wr_data = 64'd0;
    b_issue_valid = 1'b0; b_issue_rs_used = 3'b000; b_issue_rd_we = 1'b0;
    b_issue_rd = 5'd0; b_flush = 1'b0;
    chk(A_RD0, 64'd0, "reset_rd0_x5");
    chk(A_RD1, 64'd0, "reset_rd1_x5");
    chk(A_STALL, 64'd0, "reset_stall");
    chk(A_SBERR, 64'd0, "reset_sberr");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Bypass and x0
    a_cyc(1'b1, 2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0);
    chk(A_STALL, 64'd0, "issue_x5_accept");
    a_cyc(1'b0, 2'b00, 5'd5, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
    chk(A_RD1, 64'hDEAD_BEEF, "bypass_x5_p1");
    chk(A_RD0, 64'hDEAD_BEEF, "bypass_x5_p0");
    a_cyc(1'b0, 2'b00, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk(A_RD1, 64'hDEAD_BEEF, "stored_x5");
    chk(A_SBERR, 64'd0, "no_sberr_after_x5");
    a_cyc(1'b0, 2'b00, 5'd0, 5'd5, 1'b0, 5'd0, 1'b1, 5'd0, 32'h0000_1234, 1'b0);
    chk(A_RD0, 64'd0, "x0_bypass_blocked");
    a_cyc(1'b0, 2'b00, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk(A_RD0, 64'd0, "x0_stored_zero");
    chk(A_SBERR, 64'd0, "x0_write_no_sberr");

    // RAW hazard on x7
    a_cyc(1'b1, 2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0);
    chk(A_STALL, 64'd0, "issue_x7_accept");
    a_cyc(1'b1, 2'b01, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk(A_STALL, 64'd1, "raw_x7_stall");
    a_cyc(1'b1, 2'b01, 5'd7, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h0000_0777, 1'b0);
    chk(A_STALL, 64'd0, "raw_x7_wb_resolves");
    chk(A_RD0, 64'h0000_0777, "raw_x7_bypass");
    a_cyc(1'b1, 2'b01, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk(A_STALL, 64'd0, "raw_x7_cleared");
    chk(A_RD0, 64'h0000_0777, "x7_stored");

    // Saturation on x9
    for (int k = 0; k < 3; k++) begin
      a_cyc(1'b1, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0);
      chk(A_STALL, 64'd0, "issue_x9_accept");
    end
    a_cyc(1'b1, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0);
    chk(A_STALL, 64'd1, "full_x9_stall");
    a_cyc(1'b1, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 5'd9, 32'h0000_0099, 1'b0);
    chk(A_STALL, 64'd0, "full_x9_wb_accept");
    a_cyc(1'b1, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0);
    chk(A_STALL, 64'd1, "full_x9_still_three");
    chk(A_SBERR, 64'd0, "no_sberr_x9");

    // Flush
    a_cyc(1'b1, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0);
    a_cyc(1'b1, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0);
    a_cyc(1'b1, 2'b01, 5'd9, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 1'b1);
    chk(A_STALL, 64'd0, "flush_no_stall");
    a_cyc(1'b1, 2'b11, 5'd9, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk(A_STALL, 64'd0, "after_flush_clear");
    a_cyc(1'b0, 2'b00, 5'd0, 5'd3, 1'b0, 5'd0, 1'b1, 5'd3, 32'h0000_0033, 1'b0);
    chk(A_SBERR, 64'd0, "sberr_not_yet");
    chk(A_RD1, 64'h0000_0033, "x3_bypass");
    a_cyc(1'b0, 2'b00, 5'd0, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk(A_SBERR, 64'd1, "sberr_set");
    chk(A_RD1, 64'h0000_0033, "x3_written");

    // Reset mid-operation
    a_cyc(1'b1, 2'b00, 5'd0, 5'd5, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0);
    chk(A_STALL, 64'd0, "issue_x4_accept");
    a_cyc(1'b1, 2'b01, 5'd4, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    rst_n = 1'b0;
    chk(A_STALL, 64'd0, "midreset_stall");
    chk(A_SBERR, 64'd0, "midreset_sberr");
    chk(A_RD1, 64'd0, "midreset_x5");
    a_cyc(1'b1, 2'b01, 5'd4, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    rst_n = 1'b1;
    chk(A_STALL, 64'd0, "postreset_stall");
    chk(A_RD1, 64'd0, "postreset_x3");
    chk(A_RD0, 64'd0, "postreset_x4");
    a_cyc(1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);

    // Wide configuration
    b_cyc(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd10, 1'b0, 5'd0, 64'd0);
    chk(B_STALL, 64'd0, "b_issue_x10");
    b_cyc(1'b1, 3'b111, 5'd11, 5'd10, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0);
    chk(B_STALL, 64'd1, "b_raw_stall");
    b_cyc(1'b1, 3'b111, 5'd11, 5'd10, 5'd12, 1'b0, 5'd0, 1'b1, 5'd10, 64'hFEDC_BA98_7654_3210);
    chk(B_STALL, 64'd0, "b_raw_resolved");
    chk(B_RD1, 64'hFEDC_BA98_7654_3210, "b_bypass_p1");
    chk(B_RD0, 64'd0, "b_p0_unaffected");
    chk(B_RD2, 64'd0, "b_p2_unaffected");
    b_cyc(1'b0, 3'b000, 5'd11, 5'd10, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0);
    chk(B_RD1, 64'hFEDC_BA98_7654_3210, "b_stored_x10");
    chk(B_SBERR, 64'd0, "b_no_sberr");

    @(posedge clk);
    @(posedge clk);
    if (q_sel.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL queue_drain: %0d left, expected 0", q_sel.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
